lpif_txrx_x8_q2_master_link: RTL and testbench
==============================================

# lpif_txrx_x8_q2_master_link

Master-side (upstream-die) LPIF-over-AIB link adapter for the x8 / quarter-rate-2 configuration: packs the downstream LPIF channel into 529-bit logic-link words and unpacks 529-bit upstream words back into the upstream LPIF channel. It sits between the master LPIF adapter and the logic-link TX/RX FIFOs. Its far-end counterpart is the slave-side x8/q2 pack/unpack on the other die. It adds a 2-entry downstream buffer with backpressure, state-change forwarding, a registered upstream stage and an overflow error flag.

## Interface
- Parameters:
- PKT_W, 529, logic-link word width; fixed by field layout, not overridable in practice.
- DATA_W, 512, LPIF data width.
- Ports:
- lclk  in  1  LPIF clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- dstrm_state / dstrm_protid / dstrm_data / dstrm_dvalid / dstrm_crc / dstrm_crc_valid / dstrm_valid  in  4/2/512/1/8/1/1  downstream LPIF fields from adapter.
- dstrm_ready  out  1  buffer can accept a word this cycle.
- dstrm_overflow  out  1  sticky: a word was offered while dstrm_ready=0.
- txfifo_downstream_data  out  529  packed word to logic-link TX FIFO.
- txfifo_downstream_push  out  1  word valid and consumed this cycle.
- txfifo_downstream_ready  in  1  TX FIFO not full.
- rxfifo_upstream_data  in  529  packed word from logic-link RX FIFO.
- rxfifo_upstream_vld  in  1  rxfifo_upstream_data valid this cycle.
- ustrm_state / ustrm_protid / ustrm_data / ustrm_dvalid / ustrm_crc / ustrm_crc_valid / ustrm_valid  out  4/2/512/1/8/1/1  upstream LPIF fields to adapter.

## Operation
- Word layout (both directions): state[3:0] at bits 0-3, protid 4-5, data 6-517, dvalid 518, crc 519-526, crc_valid 527, valid 528.
- Downstream offer: offer = dstrm_valid OR (dstrm_state != last_state). Accept = offer AND dstrm_ready. On accept, packed word written to buffer tail, last_state <= dstrm_state.
- last_state resets to 4'h0; state-only words carry valid=0, dvalid=0, crc_valid=0 as presented.
- Buffer: 2 entries, count 0..2. dstrm_ready = !reset AND (count != 2); derived from registered count only, no combinational path from txfifo_downstream_ready.
- txfifo_downstream_push = (count != 0) AND txfifo_downstream_ready; txfifo_downstream_data = head entry (zero when empty). Push pops head.
- Simultaneous accept and push: count unchanged, order preserved (FIFO, never reorders or duplicates).
- Overflow: offer AND !dstrm_ready sets dstrm_overflow; word dropped, last_state not updated; flag clears only on reset.
- Upstream: when rxfifo_upstream_vld=1, all ustrm_* registered from unpacked word. When 0: ustrm_valid, ustrm_dvalid, ustrm_crc_valid <= 0; ustrm_state, protid, data, crc hold last value.

## Timing
- Reset (synchronous): count=0, buffer entries 0, last_state=0, dstrm_overflow=0, all ustrm_* = 0, txfifo_downstream_push=0, dstrm_ready=0 while reset high, 1 the first cycle after.
- Downstream latency: word accepted in cycle N is pushable at N+1 earliest (push at N+1 if txfifo_downstream_ready=1 and it is head).
- Sustained throughput 1 word/cycle when txfifo_downstream_ready stays high.
- Upstream latency: exactly 1 cycle from rxfifo_upstream_vld to ustrm_* update.
- Reset mid-operation: buffered words discarded, no push in reset cycle or the cycle after.

## Structure
- Shared package lpif_txrx_pkg: PKT_W, field offset/width localparams (STATE_LSB=0 … VALID_LSB=528), LPIF state encoding constant LPIF_STATE_RESET=4'h0, pack/unpack functions.
- One sub-module: lpif_txrx_skid_fifo2 (2-entry parameterised-width FIFO with count, push/pop, full/empty).

## Test plan
- Reset then dstrm_valid=1, data=512'hA5…A5, state=4'h1, txfifo ready=1 -> push next cycle, word bits[5:0]=6'h01, [517:6]=A5 pattern, bit528=1.
- Hold txfifo_downstream_ready=0, offer 3 valid words -> first two accepted, dstrm_ready=0 after 2nd, 3rd sets dstrm_overflow=1; release ready -> exactly words 1,2 pushed in order.
- dstrm_valid=0, state 0->4'h1 -> one state-only word with bit528=0, bits[3:0]=1; state held at 1 -> no further push.
- Back-to-back 8 valid words with ready toggling every cycle -> all 8 pushed in order, no loss, no overflow.
- rxfifo_upstream_vld=1 with word crc=8'h3C, valid=1, state=4'h2, then vld=0 -> next cycle ustrm_crc=8'h3C, ustrm_valid=1, ustrm_state=2; following cycle ustrm_valid=0, ustrm_state still 2.
- Assert reset with 2 words buffered -> no push, dstrm_ready=0 during reset, overflow cleared, ustrm_* = 0.

Source files
------------

// File: rtl/lpif_txrx_pkg.sv
// Shared definitions for the x8/q2 LPIF-over-AIB link adapter: the 529-bit
// logic-link word layout and the helpers that pack/unpack it.
package lpif_txrx_pkg;

    localparam int PKT_W         = 529;
    localparam int STATE_LSB     = 0;
    localparam int STATE_W       = 4;
    localparam int PROTID_LSB    = 4;
    localparam int PROTID_W      = 2;
    localparam int DATA_LSB      = 6;
    localparam int DATA_W        = 512;
    localparam int DVALID_LSB    = 518;
    localparam int CRC_LSB       = 519;
    localparam int CRC_W         = 8;
    localparam int CRC_VALID_LSB = 527;
    localparam int VALID_LSB     = 528;

    localparam logic [3:0] LPIF_STATE_RESET = 4'h0;

    typedef struct packed {
        logic              valid;
        logic              crc_valid;
        logic [CRC_W-1:0]  crc;
        logic              dvalid;
        logic [DATA_W-1:0] data;
        logic [PROTID_W-1:0] protid;
        logic [STATE_W-1:0]  state;
    } lpif_word_t;

    function automatic logic [PKT_W-1:0] lpif_pack(input lpif_word_t w);
        logic [PKT_W-1:0] p;
        p = '0;
        p[STATE_LSB +: STATE_W]   = w.state;
        p[PROTID_LSB +: PROTID_W] = w.protid;
        p[DATA_LSB +: DATA_W]     = w.data;
        p[DVALID_LSB]             = w.dvalid;
        p[CRC_LSB +: CRC_W]       = w.crc;
        p[CRC_VALID_LSB]          = w.crc_valid;
        p[VALID_LSB]              = w.valid;
        return p;
    endfunction

    function automatic lpif_word_t lpif_unpack(input logic [PKT_W-1:0] p);
        lpif_word_t w;
        w.state     = p[STATE_LSB +: STATE_W];
        w.protid    = p[PROTID_LSB +: PROTID_W];
        w.data      = p[DATA_LSB +: DATA_W];
        w.dvalid    = p[DVALID_LSB];
        w.crc       = p[CRC_LSB +: CRC_W];
        w.crc_valid = p[CRC_VALID_LSB];
        w.valid     = p[VALID_LSB];
        return w;
    endfunction

endpackage

// File: rtl/lpif_txrx_skid_fifo2.sv
// Two-entry FIFO with full/empty flags; the head is presented combinationally
// and reads as zero while empty.
module lpif_txrx_skid_fifo2 #(
    parameter int W = 529
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] mem_reg [2];
    logic         wr_ptr_reg;
    logic         rd_ptr_reg;
    logic [1:0]   count_reg;
    logic         do_push;
    logic         do_pop;

    assign full    = (count_reg == 2'd2);
    assign empty   = (count_reg == 2'd0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = empty ? '0 : mem_reg[rd_ptr_reg];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (srst) begin
                    mem_reg[gi] <= '0;
                end else if (do_push && (wr_ptr_reg == 1'(gi))) begin
                    mem_reg[gi] <= din;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (do_push) wr_ptr_reg <= !wr_ptr_reg;
            if (do_pop)  rd_ptr_reg <= !rd_ptr_reg;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/lpif_txrx_x8_q2_master_link.sv
// Master-side x8/q2 LPIF link adapter: buffered downstream packing with
// state-change forwarding and overflow flag, registered upstream unpacking.
module lpif_txrx_x8_q2_master_link #(
    parameter int PKT_W  = 529,
    parameter int DATA_W = 512
) (
    input  logic              lclk,
    input  logic              reset,
    input  logic [3:0]        dstrm_state,
    input  logic [1:0]        dstrm_protid,
    input  logic [DATA_W-1:0] dstrm_data,
    input  logic              dstrm_dvalid,
    input  logic [7:0]        dstrm_crc,
    input  logic              dstrm_crc_valid,
    input  logic              dstrm_valid,
    output logic              dstrm_ready,
    output logic              dstrm_overflow,
    output logic [PKT_W-1:0]  txfifo_downstream_data,
    output logic              txfifo_downstream_push,
    input  logic              txfifo_downstream_ready,
    input  logic [PKT_W-1:0]  rxfifo_upstream_data,
    input  logic              rxfifo_upstream_vld,
    output logic [3:0]        ustrm_state,
    output logic [1:0]        ustrm_protid,
    output logic [DATA_W-1:0] ustrm_data,
    output logic              ustrm_dvalid,
    output logic [7:0]        ustrm_crc,
    output logic              ustrm_crc_valid,
    output logic              ustrm_valid
);
    import lpif_txrx_pkg::*;

    lpif_word_t         dn_word;
    lpif_word_t         up_reg;
    logic [PKT_W-1:0]   dn_packed;
    logic [3:0]         last_state_reg;
    logic               overflow_reg;
    logic               fifo_full;
    logic               fifo_empty;
    logic               offer;
    logic               accept;
    logic               pop;

    always_comb begin
        dn_word           = '0;
        dn_word.state     = dstrm_state;
        dn_word.protid    = dstrm_protid;
        dn_word.data      = dstrm_data;
        dn_word.dvalid    = dstrm_dvalid;
        dn_word.crc       = dstrm_crc;
        dn_word.crc_valid = dstrm_crc_valid;
        dn_word.valid     = dstrm_valid;
    end

    assign dn_packed = lpif_pack(dn_word);

    // State changes are forwarded even without data so the far die tracks the link state.
    assign offer       = dstrm_valid || (dstrm_state != last_state_reg);
    assign dstrm_ready = !reset && !fifo_full;
    assign accept      = offer && dstrm_ready;
    assign pop         = !reset && !fifo_empty && txfifo_downstream_ready;

    assign txfifo_downstream_push = pop;
    assign dstrm_overflow         = overflow_reg;

    lpif_txrx_skid_fifo2 #(
        .W (PKT_W)
    ) u_buf (
        .clk   (lclk),
        .srst  (reset),
        .push  (accept),
        .pop   (pop),
        .din   (dn_packed),
        .dout  (txfifo_downstream_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge lclk) begin
        if (reset) begin
            last_state_reg <= LPIF_STATE_RESET;
            overflow_reg   <= 1'b0;
        end else begin
            if (accept) last_state_reg <= dstrm_state;
            if (offer && !dstrm_ready) overflow_reg <= 1'b1;
        end
    end

    // Qualifiers drop when idle; payload fields keep their last value.
    always_ff @(posedge lclk) begin
        if (reset) begin
            up_reg <= '0;
        end else if (rxfifo_upstream_vld) begin
            up_reg <= lpif_unpack(rxfifo_upstream_data);
        end else begin
            up_reg.valid     <= 1'b0;
            up_reg.dvalid    <= 1'b0;
            up_reg.crc_valid <= 1'b0;
        end
    end

    assign ustrm_state     = up_reg.state;
    assign ustrm_protid    = up_reg.protid;
    assign ustrm_data      = up_reg.data;
    assign ustrm_dvalid    = up_reg.dvalid;
    assign ustrm_crc       = up_reg.crc;
    assign ustrm_crc_valid = up_reg.crc_valid;
    assign ustrm_valid     = up_reg.valid;

endmodule

// File: tb/tb_lpif_txrx_x8_q2_master_link.sv
// Directed bench for the x8/q2 master link adapter: a per-cycle downstream
// vector table plus hand-written back-to-back, upstream and reset sequences.
module tb_lpif_txrx_x8_q2_master_link;

    logic         lclk = 1'b0;
    logic         reset;
    logic [3:0]   dstrm_state;
    logic [1:0]   dstrm_protid;
    logic [511:0] dstrm_data;
    logic         dstrm_dvalid;
    logic [7:0]   dstrm_crc;
    logic         dstrm_crc_valid;
    logic         dstrm_valid;
    logic         dstrm_ready;
    logic         dstrm_overflow;
    logic [528:0] txfifo_downstream_data;
    logic         txfifo_downstream_push;
    logic         txfifo_downstream_ready;
    logic [528:0] rxfifo_upstream_data;
    logic         rxfifo_upstream_vld;
    logic [3:0]   ustrm_state;
    logic [1:0]   ustrm_protid;
    logic [511:0] ustrm_data;
    logic         ustrm_dvalid;
    logic [7:0]   ustrm_crc;
    logic         ustrm_crc_valid;
    logic         ustrm_valid;

    int errors = 0;
    int checks = 0;

    always #5 lclk = ~lclk;

    lpif_txrx_x8_q2_master_link dut (
        .lclk                    (lclk),
        .reset                   (reset),
        .dstrm_state             (dstrm_state),
        .dstrm_protid            (dstrm_protid),
        .dstrm_data              (dstrm_data),
        .dstrm_dvalid            (dstrm_dvalid),
        .dstrm_crc               (dstrm_crc),
        .dstrm_crc_valid         (dstrm_crc_valid),
        .dstrm_valid             (dstrm_valid),
        .dstrm_ready             (dstrm_ready),
        .dstrm_overflow          (dstrm_overflow),
        .txfifo_downstream_data  (txfifo_downstream_data),
        .txfifo_downstream_push  (txfifo_downstream_push),
        .txfifo_downstream_ready (txfifo_downstream_ready),
        .rxfifo_upstream_data    (rxfifo_upstream_data),
        .rxfifo_upstream_vld     (rxfifo_upstream_vld),
        .ustrm_state             (ustrm_state),
        .ustrm_protid            (ustrm_protid),
        .ustrm_data              (ustrm_data),
        .ustrm_dvalid            (ustrm_dvalid),
        .ustrm_crc               (ustrm_crc),
        .ustrm_crc_valid         (ustrm_crc_valid),
        .ustrm_valid             (ustrm_valid)
    );

    typedef struct {
        logic       rst;
        logic [3:0] st;
        logic       vld;
        logic [7:0] dat;
        logic       txr;
        logic       e_ready;
        logic       e_push;
        logic       e_ovf;
        logic [3:0] e_st;
        logic       e_v;
        logic [7:0] e_dat;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [528:0] act, input logic [528:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge lclk);
        #1;
    endtask

    function automatic logic [528:0] exp_word(input logic v, input logic cv, input logic [7:0] crc,
                                              input logic dv, input logic [511:0] d,
                                              input logic [1:0] pid, input logic [3:0] st);
        return {v, cv, crc, dv, d, pid, st};
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        dstrm_valid = 1'b0;
        dstrm_dvalid = 1'b0;
        dstrm_state = 4'h0;
        rxfifo_upstream_vld = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        logic [528:0] q[$];
        logic [528:0] w;
        logic [511:0] d;
        int sent;
        int got;

        tbl[0]  = '{1'b1, 4'h0, 1'b0, 8'h00, 1'b1,  1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 8'h00};
        tbl[1]  = '{1'b0, 4'h1, 1'b1, 8'hA5, 1'b1,  1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 8'h00};
        tbl[2]  = '{1'b0, 4'h1, 1'b0, 8'h00, 1'b1,  1'b1, 1'b1, 1'b0, 4'h1, 1'b1, 8'hA5};
        tbl[3]  = '{1'b0, 4'h1, 1'b1, 8'h11, 1'b0,  1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 8'h00};
        tbl[4]  = '{1'b0, 4'h1, 1'b1, 8'h22, 1'b0,  1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 8'h00};
        tbl[5]  = '{1'b0, 4'h1, 1'b1, 8'h33, 1'b0,  1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 8'h00};
        tbl[6]  = '{1'b0, 4'h1, 1'b0, 8'h00, 1'b1,  1'b0, 1'b1, 1'b1, 4'h1, 1'b1, 8'h11};
        tbl[7]  = '{1'b0, 4'h1, 1'b0, 8'h00, 1'b1,  1'b1, 1'b1, 1'b1, 4'h1, 1'b1, 8'h22};
        tbl[8]  = '{1'b0, 4'h1, 1'b0, 8'h00, 1'b1,  1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 8'h00};
        tbl[9]  = '{1'b0, 4'h3, 1'b0, 8'h5A, 1'b1,  1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 8'h00};
        tbl[10] = '{1'b0, 4'h3, 1'b0, 8'h00, 1'b1,  1'b1, 1'b1, 1'b1, 4'h3, 1'b0, 8'h5A};
        tbl[11] = '{1'b0, 4'h3, 1'b0, 8'h00, 1'b1,  1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 8'h00};

        dstrm_protid = 2'b00;
        dstrm_data = '0;
        dstrm_crc = 8'h00;
        dstrm_crc_valid = 1'b0;
        txfifo_downstream_ready = 1'b1;
        rxfifo_upstream_data = '0;
        do_reset();
        reset = 1'b1;

        chk("rst_ustrm_valid", 529'(ustrm_valid), 529'(0));
        chk("rst_ustrm_state", 529'(ustrm_state), 529'(0));
        chk("rst_ustrm_crc",   529'(ustrm_crc),   529'(0));
        chk("rst_ustrm_data",  529'(ustrm_data),  529'(0));

        // Per-cycle downstream table: inputs driven, outputs checked before the next edge.
        for (int i = 0; i < 12; i++) begin
            reset = tbl[i].rst;
            dstrm_state = tbl[i].st;
            dstrm_valid = tbl[i].vld;
            dstrm_dvalid = tbl[i].vld;
            dstrm_data = {64{tbl[i].dat}};
            txfifo_downstream_ready = tbl[i].txr;
            #3;
            chk($sformatf("row%0d_ready", i), 529'(dstrm_ready), 529'(tbl[i].e_ready));
            chk($sformatf("row%0d_push", i), 529'(txfifo_downstream_push), 529'(tbl[i].e_push));
            chk($sformatf("row%0d_overflow", i), 529'(dstrm_overflow), 529'(tbl[i].e_ovf));
            if (tbl[i].e_push) begin
                d = {64{tbl[i].e_dat}};
                chk($sformatf("row%0d_word", i), txfifo_downstream_data,
                    exp_word(tbl[i].e_v, 1'b0, 8'h00, tbl[i].e_v, d, 2'b00, tbl[i].e_st));
            end
            $display("vec %0d: st=%h vld=%0d txr=%0d ready=%0d push=%0d ovf=%0d",
                     i, tbl[i].st, tbl[i].vld, tbl[i].txr, dstrm_ready,
                     txfifo_downstream_push, dstrm_overflow);
            tick();
        end

        // Back-to-back words with TX FIFO ready toggling; the source honours dstrm_ready.
        do_reset();
        sent = 0;
        got = 0;
        for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
            txfifo_downstream_ready = cyc[0];
            if (sent < 8 && dstrm_ready) begin
                d = {16{32'hC0DE0000 + 32'(sent)}};
                dstrm_valid = 1'b1;
                dstrm_dvalid = 1'b1;
                dstrm_data = d;
                q.push_back(exp_word(1'b1, 1'b0, 8'h00, 1'b1, d, 2'b00, 4'h0));
                sent++;
            end else begin
                dstrm_valid = 1'b0;
                dstrm_dvalid = 1'b0;
            end
            #3;
            if (txfifo_downstream_push) begin
                if (q.size() == 0) begin
                    chk("b2b_unexpected_push", 529'(1), 529'(0));
                end else begin
                    w = q.pop_front();
                    chk($sformatf("b2b_word%0d", got), txfifo_downstream_data, w);
                    $display("b2b push %0d: data[37:6]=%h", got, txfifo_downstream_data[37:6]);
                end
                got++;
            end
            tick();
        end
        dstrm_valid = 1'b0;
        dstrm_dvalid = 1'b0;
        chk("b2b_push_count", 529'(got), 529'(8));
        chk("b2b_overflow", 529'(dstrm_overflow), 529'(0));

        // Upstream: one valid word, then idle.
        rxfifo_upstream_data = exp_word(1'b1, 1'b1, 8'h3C, 1'b1, {16{32'h1234ABCD}}, 2'b01, 4'h2);
        rxfifo_upstream_vld = 1'b1;
        #3;
        chk("up_before_edge_valid", 529'(ustrm_valid), 529'(0));
        tick();
        rxfifo_upstream_vld = 1'b0;
        rxfifo_upstream_data = '0;
        #3;
        chk("up_crc",       529'(ustrm_crc),       529'(8'h3C));
        chk("up_valid",     529'(ustrm_valid),     529'(1));
        chk("up_state",     529'(ustrm_state),     529'(4'h2));
        chk("up_protid",    529'(ustrm_protid),    529'(2'b01));
        chk("up_dvalid",    529'(ustrm_dvalid),    529'(1));
        chk("up_crc_valid", 529'(ustrm_crc_valid), 529'(1));
        chk("up_data",      529'(ustrm_data),      529'({16{32'h1234ABCD}}));
        $display("upstream word: state=%h crc=%h valid=%0d", ustrm_state, ustrm_crc, ustrm_valid);
        tick();
        #3;
        chk("up_idle_valid",     529'(ustrm_valid),     529'(0));
        chk("up_idle_dvalid",    529'(ustrm_dvalid),    529'(0));
        chk("up_idle_crc_valid", 529'(ustrm_crc_valid), 529'(0));
        chk("up_idle_state",     529'(ustrm_state),     529'(4'h2));
        chk("up_idle_crc",       529'(ustrm_crc),       529'(8'h3C));
        $display("upstream idle: state=%h crc=%h valid=%0d", ustrm_state, ustrm_crc, ustrm_valid);
        tick();

        // Reset with two words buffered and overflow set.
        txfifo_downstream_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            dstrm_valid = 1'b1;
            dstrm_dvalid = 1'b1;
            dstrm_data = {64{8'(8'h70 + k)}};
            tick();
        end
        dstrm_valid = 1'b0;
        dstrm_dvalid = 1'b0;
        #3;
        chk("pre_rst_ready",    529'(dstrm_ready),    529'(0));
        chk("pre_rst_overflow", 529'(dstrm_overflow), 529'(1));
        tick();
        reset = 1'b1;
        txfifo_downstream_ready = 1'b1;
        #3;
        chk("in_rst_push",  529'(txfifo_downstream_push), 529'(0));
        chk("in_rst_ready", 529'(dstrm_ready),            529'(0));
        tick();
        reset = 1'b0;
        #3;
        chk("post_rst_push",     529'(txfifo_downstream_push), 529'(0));
        chk("post_rst_ready",    529'(dstrm_ready),            529'(1));
        chk("post_rst_overflow", 529'(dstrm_overflow),         529'(0));
        chk("post_rst_ustrm_state", 529'(ustrm_state), 529'(0));
        chk("post_rst_ustrm_crc",   529'(ustrm_crc),   529'(0));
        chk("post_rst_ustrm_data",  529'(ustrm_data),  529'(0));
        $display("reset mid-op: push=%0d ready=%0d ovf=%0d", txfifo_downstream_push,
                 dstrm_ready, dstrm_overflow);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
